// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  // 0 = data stage (req0), 1 = instruction fetch (req1)
  typedef logic grant_t;

  localparam grant_t GRANT_DATA  = 1'b0;
  localparam grant_t GRANT_FETCH = 1'b1;

endpackage

// File: rtl/mux64x2_1.sv
// Two-input word multiplexer used to steer requester address and write data.
module mux64x2_1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the data stage (req0, priority) and fetch (req1),
// holding the port for LAT cycles per transaction with anti-starvation for req1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int LAT        = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  input  logic             req0_we,
  output logic             req0_ready,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_addr,
  output logic             req1_ready,
  output logic             req1_done,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] resp_data
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  arb_state_t       state, state_nxt;
  grant_t           grant, owner;
  logic             grant_vld;
  logic             last_cyc;
  logic [CNT_W-1:0] cnt;
  logic [STV_W-1:0] starve_cnt;
  logic [WIDTH-1:0] addr_sel, wdata_sel;
  logic [WIDTH-1:0] mem_addr_p1, mem_wdata_p1, resp_data_p2;
  logic             mem_we_p1, done0_p2, done1_p2;

  mux64x2_1 #(.WIDTH(WIDTH)) u_addr_mux (
    .d0  (req0_addr),
    .d1  (req1_addr),
    .sel (grant),
    .y   (addr_sel)
  );

  // Fetch is read-only, so its write-data leg is tied off.
  mux64x2_1 #(.WIDTH(WIDTH)) u_wdata_mux (
    .d0  (req0_wdata),
    .d1  ('0),
    .sel (grant),
    .y   (wdata_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = GRANT_DATA;
    grant_vld  = 1'b0;
    last_cyc   = (state == ACCESS) && (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (req0_valid && !(req1_valid && starve_cnt == STV_SAT)) begin
          grant_vld = 1'b1;
          grant     = GRANT_DATA;
        end else if (req1_valid) begin
          grant_vld = 1'b1;
          grant     = GRANT_FETCH;
        end
        if (grant_vld) state_nxt = ACCESS;
      end
      ACCESS: if (last_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant_vld && (grant == GRANT_DATA);
  assign req1_ready = grant_vld && (grant == GRANT_FETCH);

  // p1: grant captures the request; p2: last access cycle captures the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      starve_cnt   <= '0;
      owner        <= GRANT_DATA;
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      resp_data_p2 <= '0;
      done0_p2     <= 1'b0;
      done1_p2     <= 1'b0;
    end else begin
      done0_p2 <= 1'b0;
      done1_p2 <= 1'b0;
      if (grant_vld) begin
        mem_addr_p1  <= addr_sel;
        mem_wdata_p1 <= wdata_sel;
        mem_we_p1    <= req0_we & ~grant;
        owner        <= grant;
        cnt          <= '0;
        if (grant == GRANT_FETCH)
          starve_cnt <= '0;
        else if (req1_valid && starve_cnt != STV_SAT)
          starve_cnt <= starve_cnt + STV_W'(1);
      end
      if (state == ACCESS) cnt <= cnt + CNT_W'(1);
      if (last_cyc) begin
        if (!mem_we_p1) resp_data_p2 <= mem_rdata;
        done0_p2 <= (owner == GRANT_DATA);
        done1_p2 <= (owner == GRANT_FETCH);
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_we_p1 & mem_en;
  assign mem_addr  = mem_addr_p1;
  assign mem_wdata = mem_wdata_p1;
  assign resp_data = resp_data_p2;
  assign req0_done = done0_p2;
  assign req1_done = done1_p2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a countdown transaction model.
module tb_mem_port_arbiter;

  localparam int W  = 64;
  localparam int LT = 3;
  localparam int SM = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_we, req1_valid;
  logic [W-1:0] req0_addr, req0_wdata, req1_addr, mem_rdata;
  logic         req0_ready, req0_done, req1_ready, req1_done, mem_en, mem_we;
  logic [W-1:0] mem_addr, mem_wdata, resp_data;

  mem_port_arbiter #(.WIDTH(W), .LAT(LT), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_we(req0_we), .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .req1_done(req1_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int gq[$];
  int r1_cyc[$];
  int r1_done_at[$];

  // Model: remaining access cycles of the transaction in flight plus its captured fields.
  int           m_remain, m_starve;
  logic         m_owner, m_we, m_done0, m_done1;
  logic [W-1:0] m_addr, m_wdata, m_resp;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_remain = 0; m_starve = 0; m_owner = 0; m_we = 0;
    m_done0 = 0; m_done1 = 0; m_addr = '0; m_wdata = '0; m_resp = '0;
  endfunction

  function automatic void model_grant(output logic gv, output logic g);
    gv = 0; g = 0;
    if (m_remain == 0) begin
      if (req0_valid && !(req1_valid && m_starve == SM)) gv = 1;
      else if (req1_valid) begin gv = 1; g = 1; end
    end
  endfunction

  function automatic void model_step(input logic gv, input logic g);
    m_done0 = 0; m_done1 = 0;
    if (m_remain > 0) begin
      if (m_remain == 1) begin
        if (m_owner) m_done1 = 1; else m_done0 = 1;
        if (!m_we) m_resp = mem_rdata;
      end
      m_remain--;
    end else if (gv) begin
      m_remain = LT;
      m_owner  = g;
      m_we     = g ? 1'b0 : req0_we;
      m_addr   = g ? req1_addr : req0_addr;
      m_wdata  = g ? '0 : req0_wdata;
      if (g) m_starve = 0;
      else if (req1_valid) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    end
  endfunction

  task automatic check_outputs();
    chk("mem_en",    mem_en,    m_remain > 0);
    chk("mem_we",    mem_we,    (m_remain > 0) && m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("resp_data", resp_data, m_resp);
    chk("req0_done", req0_done, m_done0);
    chk("req1_done", req1_done, m_done1);
    if (req0_done && req1_done) chk("done_overlap", 1, 0);
  endtask

  task automatic chk_zero();
    chk("rst_en", mem_en, 0);       chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);   chk("rst_wdata", mem_wdata, 0);
    chk("rst_resp", resp_data, 0);  chk("rst_done0", req0_done, 0);
    chk("rst_done1", req1_done, 0);
  endtask

  // Called at a negedge with inputs already driven; ends at the following negedge.
  task automatic cycle();
    logic gv, g;
    #1;
    model_grant(gv, g);
    chk("req0_ready", req0_ready, gv && !g);
    chk("req1_ready", req1_ready, gv && g);
    if (req0_ready) gq.push_back(0);
    if (req1_ready) begin
      gq.push_back(1);
      r1_cyc.push_back(cyc);
      r1_done_at.push_back(int'(req1_done));
    end
    @(posedge clk);
    model_step(gv, g);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk_zero();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_we = 0;
  endtask

  initial begin
    int pat[10];
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    reset = 1'b1;
    idle_inputs();
    req0_addr = '0; req0_wdata = '0; req1_addr = '0; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero();
    reset = 1'b0;

    // Idle after reset
    repeat (10) cycle();
    chk("idle_en_lit", mem_en, 0);

    // req0 read at 0x100, memory returns 0xDEAD in the last access cycle
    req0_valid = 1; req0_addr = 64'h100; req0_we = 0;
    #1 chk("lit_ready0", req0_ready, 1);
    cycle();
    idle_inputs();
    chk("lit_en_t1", mem_en, 1);
    chk("lit_addr_t1", mem_addr, 64'h100);
    cycle();
    mem_rdata = 64'hDEAD;
    cycle();
    chk("lit_en_t3", mem_en, 1);
    cycle();
    chk("lit_done0_t4", req0_done, 1);
    chk("lit_resp_t4", resp_data, 64'hDEAD);
    mem_rdata = 64'h1234;

    // req0 write: resp_data must keep 0xDEAD
    req0_valid = 1; req0_addr = 64'h8; req0_wdata = 64'h55; req0_we = 1;
    cycle();
    idle_inputs();
    chk("lit_we_t1", mem_we, 1);
    chk("lit_wdata_t1", mem_wdata, 64'h55);
    repeat (3) cycle();
    chk("lit_wdone_t4", req0_done, 1);
    chk("lit_wresp_t4", resp_data, 64'hDEAD);
    chk("lit_we_idle", mem_we, 0);

    // Both requesters valid continuously from a clean starvation count
    async_reset();
    gq.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 44; i++) begin
      req0_addr = {$urandom, $urandom}; req1_addr = {$urandom, $urandom};
      req0_we = 1'($urandom); req0_wdata = {$urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();
    chk("grant_count", gq.size() >= 10, 1);
    for (int i = 0; i < 10 && i < gq.size(); i++) chk($sformatf("grant_order%0d", i), gq[i], pat[i]);

    // req1 back-to-back at 0x0 then 0x4
    r1_cyc.delete(); r1_done_at.delete();
    req1_valid = 1;
    for (int i = 0; i < 9; i++) begin
      req1_addr = (r1_cyc.size() == 0) ? 64'h0 : 64'h4;
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();
    chk("r1_grants", r1_cyc.size() >= 2, 1);
    if (r1_cyc.size() >= 2) begin
      chk("r1_spacing", r1_cyc[1] - r1_cyc[0], 4);
      chk("r1_ready_with_done", r1_done_at[1], 1);
    end

    // Reset while a req0 access is at cnt=1, then re-issue
    req0_valid = 1; req0_addr = 64'h40; req0_we = 0;
    cycle();
    idle_inputs();
    cycle();
    async_reset();
    repeat (3) cycle();
    chk("no_done_after_rst", req0_done, 0);
    req0_valid = 1; req0_addr = 64'h40; mem_rdata = 64'hBEEF;
    #1 chk("regrant_ready0", req0_ready, 1);
    cycle();
    idle_inputs();
    repeat (3) cycle();
    chk("regrant_done0", req0_done, 1);
    chk("regrant_resp", resp_data, 64'hBEEF);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_we    = 1'($urandom);
      req0_addr  = {$urandom, $urandom};
      req0_wdata = {$urandom, $urandom};
      req1_addr  = {$urandom, $urandom};
      mem_rdata  = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
